sdram_arbiter: RTL and testbench

Central command arbiter for the SDRAM controller. It sits between the command-generating sub-blocks (power-up init, auto-refresh, self-refresh, write, read) and the SDRAM pins. It grants the bus to one sub-block at a time and registers the selected CKE/command/bank/address onto the pins. The self-refresh FSM receives its enable from this block, and its CKE/command outputs are consumed here.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_arbiter_if.sv | 64 ++++++
 rtl/sdram_cmd_mux.sv | 68 ++++++
 rtl/sdram_arbiter.sv | 121 ++++++++++++
 tb/tb_sdram_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: pin command encodings and the arbiter state type.
package sdram_pkg;

  localparam int unsigned CMD_W = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_LOAD_MODE = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_SREF  = 3'd3,
    ST_WRITE = 3'd4,
    ST_READ  = 3'd5
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle between the command-generating sub-blocks, the arbiter and the SDRAM pins.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BA_W   = 2
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              sr_req;
  logic              sr_done;
  logic              sr_cke;
  logic [3:0]        sr_cmd;
  logic [BA_W-1:0]   sr_ba;
  logic [ADDR_W-1:0] sr_addr;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              sr_en;
  logic              wr_en;
  logic              rd_en;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output sr_req, sr_done, sr_cke, sr_cmd, sr_ba, sr_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, sr_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_ba, sdram_addr
  );

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  sr_req, sr_done, sr_cke, sr_cmd, sr_ba, sr_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, sr_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_cmd_mux.sv
// Selects the pin drive {cke, cmd, ba, addr} of the current bus owner.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BA_W   = 2
) (
  input  arb_state_t        state,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              sr_cke,
  input  logic [CMD_W-1:0]  sr_cmd,
  input  logic [BA_W-1:0]   sr_ba,
  input  logic [ADDR_W-1:0] sr_addr,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              cke_c,
  output logic [CMD_W-1:0]  cmd_c,
  output logic [BA_W-1:0]   ba_c,
  output logic [ADDR_W-1:0] addr_c
);

  // ARBIT (and any unknown state) idles the bus with NOP and all-ones address
  always_comb begin
    cke_c  = 1'b1;
    cmd_c  = CMD_NOP;
    ba_c   = '1;
    addr_c = '1;
    case (state)
      ST_INIT: begin
        cmd_c  = init_cmd;
        ba_c   = init_ba;
        addr_c = init_addr;
      end
      ST_AREF: begin
        cmd_c  = aref_cmd;
        ba_c   = aref_ba;
        addr_c = aref_addr;
      end
      ST_SREF: begin
        cke_c  = sr_cke;
        cmd_c  = sr_cmd;
        ba_c   = sr_ba;
        addr_c = sr_addr;
      end
      ST_WRITE: begin
        cmd_c  = wr_cmd;
        ba_c   = wr_ba;
        addr_c = wr_addr;
      end
      ST_READ: begin
        cmd_c  = rd_cmd;
        ba_c   = rd_ba;
        addr_c = rd_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: grants the pins to one sub-block at a time with fixed
// priority self-refresh > auto-refresh > write > read, and registers the pin drive.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BA_W   = 2
) (
  input logic           sys_clk,
  input logic           sys_rst,
  sdram_arbiter_if.slave bus
);

  arb_state_t        state;
  logic              mux_cke;
  logic [CMD_W-1:0]  mux_cmd;
  logic [BA_W-1:0]   mux_ba;
  logic [ADDR_W-1:0] mux_addr;

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W)
  ) u_cmd_mux (
    .state     (state),
    .init_cmd  (bus.init_cmd),
    .init_ba   (bus.init_ba),
    .init_addr (bus.init_addr),
    .aref_cmd  (bus.aref_cmd),
    .aref_ba   (bus.aref_ba),
    .aref_addr (bus.aref_addr),
    .sr_cke    (bus.sr_cke),
    .sr_cmd    (bus.sr_cmd),
    .sr_ba     (bus.sr_ba),
    .sr_addr   (bus.sr_addr),
    .wr_cmd    (bus.wr_cmd),
    .wr_ba     (bus.wr_ba),
    .wr_addr   (bus.wr_addr),
    .rd_cmd    (bus.rd_cmd),
    .rd_ba     (bus.rd_ba),
    .rd_addr   (bus.rd_addr),
    .cke_c     (mux_cke),
    .cmd_c     (mux_cmd),
    .ba_c      (mux_ba),
    .addr_c    (mux_addr)
  );

  // Owner FSM with registered grants and pins; end pulses only count for the owner
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= ST_INIT;
      bus.aref_en    <= 1'b0;
      bus.sr_en      <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.sdram_cke  <= 1'b1;
      bus.sdram_cmd  <= CMD_NOP;
      bus.sdram_ba   <= '1;
      bus.sdram_addr <= '1;
    end else begin
      bus.sdram_cke  <= mux_cke;
      bus.sdram_cmd  <= mux_cmd;
      bus.sdram_ba   <= mux_ba;
      bus.sdram_addr <= mux_addr;
      case (state)
        ST_INIT: begin
          if (bus.init_end) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          if (bus.sr_req) begin
            state     <= ST_SREF;
            bus.sr_en <= 1'b1;
          end else if (bus.aref_req) begin
            state       <= ST_AREF;
            bus.aref_en <= 1'b1;
          end else if (bus.wr_req) begin
            state     <= ST_WRITE;
            bus.wr_en <= 1'b1;
          end else if (bus.rd_req) begin
            state     <= ST_READ;
            bus.rd_en <= 1'b1;
          end
        end
        ST_AREF: begin
          if (bus.aref_end) begin
            state       <= ST_ARBIT;
            bus.aref_en <= 1'b0;
          end
        end
        // The self-refresh FSM exits when it sees its enable follow sr_req low
        ST_SREF: begin
          if (bus.sr_done) begin
            state     <= ST_ARBIT;
            bus.sr_en <= 1'b0;
          end else begin
            bus.sr_en <= bus.sr_req;
          end
        end
        ST_WRITE: begin
          if (bus.wr_end) begin
            state     <= ST_ARBIT;
            bus.wr_en <= 1'b0;
          end
        end
        ST_READ: begin
          if (bus.rd_end) begin
            state     <= ST_ARBIT;
            bus.rd_en <= 1'b0;
          end
        end
        default: begin
          state       <= ST_INIT;
          bus.aref_en <= 1'b0;
          bus.sr_en   <= 1'b0;
          bus.wr_en   <= 1'b0;
          bus.rd_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, reset corner cases, and random
// traffic checked against an owner-level reference model.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BA_W   = 2;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic ie, ar, ae, sq, sd, sk, wq, we, rq, re;
    logic aen, sen, wen, ren, cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl [18];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which sub-block owns the pins (0 init, 1 idle, 2 sref, 3 aref, 4 write, 5 read)
  int          m_owner;
  logic        e_aen, e_sen, e_wen, e_ren, e_cke;
  logic [3:0]  e_cmd;
  logic [1:0]  e_ba;
  logic [11:0] e_addr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic aen, input logic sen, input logic wen,
                            input logic ren, input logic cke, input logic [3:0] cmd,
                            input logic [1:0] ba, input logic [11:0] addr);
    cmp({tag, ".aref_en"},    32'(bus.aref_en),    32'(aen));
    cmp({tag, ".sr_en"},      32'(bus.sr_en),      32'(sen));
    cmp({tag, ".wr_en"},      32'(bus.wr_en),      32'(wen));
    cmp({tag, ".rd_en"},      32'(bus.rd_en),      32'(ren));
    cmp({tag, ".sdram_cke"},  32'(bus.sdram_cke),  32'(cke));
    cmp({tag, ".sdram_cmd"},  32'(bus.sdram_cmd),  32'(cmd));
    cmp({tag, ".sdram_ba"},   32'(bus.sdram_ba),   32'(ba));
    cmp({tag, ".sdram_addr"}, 32'(bus.sdram_addr), 32'(addr));
  endtask

  task automatic set_data();
    bus.init_cmd = CMD_PRECHARGE; bus.init_ba = 2'd0; bus.init_addr = 12'h400;
    bus.aref_cmd = CMD_AUTO_REF;  bus.aref_ba = 2'd1; bus.aref_addr = 12'h0aa;
    bus.sr_cmd   = CMD_AUTO_REF;  bus.sr_ba   = 2'd2; bus.sr_addr   = 12'h0bb;
    bus.wr_cmd   = 4'b0100;       bus.wr_ba   = 2'd0; bus.wr_addr   = 12'h123;
    bus.rd_cmd   = CMD_READ;      bus.rd_ba   = 2'd3; bus.rd_addr   = 12'h0cc;
  endtask

  task automatic set_ctrl(input logic ie, input logic ar, input logic ae, input logic sq,
                          input logic sd, input logic sk, input logic wq, input logic we,
                          input logic rq, input logic re);
    bus.init_end = ie; bus.aref_req = ar; bus.aref_end = ae;
    bus.sr_req = sq;   bus.sr_done = sd;  bus.sr_cke = sk;
    bus.wr_req = wq;   bus.wr_end = we;   bus.rd_req = rq; bus.rd_end = re;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Pins show what the owner drove during the cycle; ownership changes per the priority rules
  task automatic model_step();
    logic [3:0] req;
    int nxt;
    case (m_owner)
      0:       {e_cke, e_cmd, e_ba, e_addr} = {1'b1, bus.init_cmd, bus.init_ba, bus.init_addr};
      2:       {e_cke, e_cmd, e_ba, e_addr} = {bus.sr_cke, bus.sr_cmd, bus.sr_ba, bus.sr_addr};
      3:       {e_cke, e_cmd, e_ba, e_addr} = {1'b1, bus.aref_cmd, bus.aref_ba, bus.aref_addr};
      4:       {e_cke, e_cmd, e_ba, e_addr} = {1'b1, bus.wr_cmd, bus.wr_ba, bus.wr_addr};
      5:       {e_cke, e_cmd, e_ba, e_addr} = {1'b1, bus.rd_cmd, bus.rd_ba, bus.rd_addr};
      default: {e_cke, e_cmd, e_ba, e_addr} = {1'b1, CMD_NOP, 2'b11, 12'hfff};
    endcase
    nxt = m_owner;
    req = {bus.sr_req, bus.aref_req, bus.wr_req, bus.rd_req};
    case (m_owner)
      0: if (bus.init_end) nxt = 1;
      1: begin
        for (int i = 0; i < 4; i++) begin
          if (req[3-i]) begin
            nxt = 2 + i;
            break;
          end
        end
      end
      2: if (bus.sr_done)  nxt = 1;
      3: if (bus.aref_end) nxt = 1;
      4: if (bus.wr_end)   nxt = 1;
      5: if (bus.rd_end)   nxt = 1;
      default: nxt = 0;
    endcase
    e_sen   = (nxt == 2) && (m_owner == 1 || bus.sr_req);
    e_aen   = (nxt == 3);
    e_wen   = (nxt == 4);
    e_ren   = (nxt == 5);
    m_owner = nxt;
  endtask

  initial begin
    //            ie ar ae sq sd sk wq we rq re | aen sen wen ren cke  cmd     ba     addr
    tbl[0]  = '{T, F, F, F, F, T, F, F, F, F,   F, F, F, F, T, 4'b0010, 2'd0, 12'h400};
    tbl[1]  = '{T, T, F, F, F, T, T, F, F, F,   T, F, F, F, T, 4'b0111, 2'd3, 12'hfff};
    tbl[2]  = '{T, F, F, F, F, T, T, F, F, T,   T, F, F, F, T, 4'b0001, 2'd1, 12'h0aa};
    tbl[3]  = '{T, F, T, F, F, T, T, F, F, F,   F, F, F, F, T, 4'b0001, 2'd1, 12'h0aa};
    tbl[4]  = '{T, F, F, F, F, T, T, F, F, F,   F, F, T, F, T, 4'b0111, 2'd3, 12'hfff};
    tbl[5]  = '{T, T, F, F, F, T, T, F, F, F,   F, F, T, F, T, 4'b0100, 2'd0, 12'h123};
    tbl[6]  = '{T, T, F, F, F, T, F, T, F, F,   F, F, F, F, T, 4'b0100, 2'd0, 12'h123};
    tbl[7]  = '{T, T, F, F, F, T, F, F, F, F,   T, F, F, F, T, 4'b0111, 2'd3, 12'hfff};
    tbl[8]  = '{T, F, T, F, F, T, F, F, F, F,   F, F, F, F, T, 4'b0001, 2'd1, 12'h0aa};
    tbl[9]  = '{T, T, F, T, F, T, F, F, F, F,   F, T, F, F, T, 4'b0111, 2'd3, 12'hfff};
    tbl[10] = '{T, T, F, T, F, F, F, F, F, F,   F, T, F, F, F, 4'b0001, 2'd2, 12'h0bb};
    tbl[11] = '{T, F, F, F, F, F, F, F, F, F,   F, F, F, F, F, 4'b0001, 2'd2, 12'h0bb};
    tbl[12] = '{T, F, F, F, T, T, F, F, F, F,   F, F, F, F, T, 4'b0001, 2'd2, 12'h0bb};
    tbl[13] = '{T, F, F, F, F, T, F, F, T, F,   F, F, F, T, T, 4'b0111, 2'd3, 12'hfff};
    tbl[14] = '{T, F, T, F, F, T, F, F, T, F,   F, F, F, T, T, 4'b0101, 2'd3, 12'h0cc};
    tbl[15] = '{T, F, F, F, F, T, F, F, F, T,   F, F, F, F, T, 4'b0101, 2'd3, 12'h0cc};
    tbl[16] = '{F, F, F, F, F, T, F, F, F, F,   F, F, F, F, T, 4'b0111, 2'd3, 12'hfff};
    tbl[17] = '{F, F, F, F, F, T, F, F, T, F,   F, F, F, T, T, 4'b0111, 2'd3, 12'hfff};

    set_data();
    set_ctrl(F, F, F, F, F, T, F, F, F, F);
    #23;
    check_outs("reset", F, F, F, F, T, CMD_NOP, 2'b11, 12'hfff);
    sys_rst = 1'b0;

    // Init sequence runs 10 cycles before init_end
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0 || i == 9) check_outs($sformatf("init%0d", i), F, F, F, F, T, CMD_PRECHARGE, 2'd0, 12'h400);
    end

    for (int i = 0; i < 18; i++) begin
      set_ctrl(tbl[i].ie, tbl[i].ar, tbl[i].ae, tbl[i].sq, tbl[i].sd,
               tbl[i].sk, tbl[i].wq, tbl[i].we, tbl[i].rq, tbl[i].re);
      step();
      check_outs($sformatf("row%0d", i), tbl[i].aen, tbl[i].sen, tbl[i].wen, tbl[i].ren,
                 tbl[i].cke, tbl[i].cmd, tbl[i].ba, tbl[i].addr);
    end

    // Reset while in self-refresh with CKE low
    set_ctrl(F, F, F, F, F, T, F, F, F, T);
    step();
    check_outs("rd_done", F, F, F, F, T, CMD_READ, 2'd3, 12'h0cc);
    set_ctrl(F, F, F, T, F, F, F, F, F, F);
    step();
    check_outs("sref_grant", F, T, F, F, T, CMD_NOP, 2'd3, 12'hfff);
    step();
    check_outs("sref_cke_low", F, T, F, F, F, CMD_AUTO_REF, 2'd2, 12'h0bb);
    #3 sys_rst = 1'b1;
    #1 check_outs("async_reset", F, F, F, F, T, CMD_NOP, 2'b11, 12'hfff);
    #2 sys_rst = 1'b0;
    set_ctrl(F, F, F, F, F, T, F, F, F, F);
    step();
    check_outs("post_reset_init", F, F, F, F, T, CMD_PRECHARGE, 2'd0, 12'h400);

    // Random traffic against the owner-level model
    m_owner = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.init_end  = ($urandom_range(0, 7) == 0);
      bus.sr_req    = ($urandom_range(0, 9) == 0);
      bus.aref_req  = ($urandom_range(0, 3) == 0);
      bus.wr_req    = ($urandom_range(0, 2) == 0);
      bus.rd_req    = ($urandom_range(0, 2) == 0);
      bus.sr_done   = ($urandom_range(0, 4) == 0);
      bus.aref_end  = ($urandom_range(0, 4) == 0);
      bus.wr_end    = ($urandom_range(0, 4) == 0);
      bus.rd_end    = ($urandom_range(0, 4) == 0);
      bus.sr_cke    = 1'($urandom);
      bus.init_cmd  = 4'($urandom);  bus.init_ba = 2'($urandom); bus.init_addr = 12'($urandom);
      bus.aref_cmd  = 4'($urandom);  bus.aref_ba = 2'($urandom); bus.aref_addr = 12'($urandom);
      bus.sr_cmd    = 4'($urandom);  bus.sr_ba   = 2'($urandom); bus.sr_addr   = 12'($urandom);
      bus.wr_cmd    = 4'($urandom);  bus.wr_ba   = 2'($urandom); bus.wr_addr   = 12'($urandom);
      bus.rd_cmd    = 4'($urandom);  bus.rd_ba   = 2'($urandom); bus.rd_addr   = 12'($urandom);
      model_step();
      step();
      check_outs($sformatf("rnd%0d", c), e_aen, e_sen, e_wen, e_ren, e_cke, e_cmd, e_ba, e_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
